// File: rtl/netdma_response_buffer.sv
// -----------------------------------------------------------------------------
// netdma_response_buffer
//
// Buffers 64-bit transfer responses from the netdma engine and hands them to
// the HPS as two consecutive 32-bit reads: low word (bytes transferred) first,
// then high word (status, bit 31 forced to 1 as the valid mark). An empty
// buffer reads as zero and raises a sticky underflow flag.
//
// Ports:
//   clk_i             single clock
//   rst_n_i           asynchronous active-low reset
//   response_i        64-bit response entry from the engine
//   response_valid_i  response_i valid this cycle
//   response_ready_o  buffer accepts an entry this cycle (not full)
//   read_i            HPS read strobe, one 32-bit word per cycle
//   readdata_o        returned word, valid the cycle after read_i
//   readdatavalid_o   readdata_o valid (one cycle per read_i)
//   resp_buf_empty_o  no stored entries
//   resp_buf_full_o   RESP_FIFO_DEPTH entries stored
//   resp_count_o      number of stored entries
//   underflow_o       sticky: a read arrived while empty
// -----------------------------------------------------------------------------
module netdma_response_buffer #(
  parameter int RESP_FIFO_DEPTH = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic [63:0]                        response_i,
  input  logic                               response_valid_i,
  output logic                               response_ready_o,
  input  logic                               read_i,
  output logic [31:0]                        readdata_o,
  output logic                               readdatavalid_o,
  output logic                               resp_buf_empty_o,
  output logic                               resp_buf_full_o,
  output logic [$clog2(RESP_FIFO_DEPTH):0]   resp_count_o,
  output logic                               underflow_o
);

  localparam int AW = $clog2(RESP_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RESP_FIFO_DEPTH);

  typedef enum logic [0:0] {
    FIRST_HALF_S  = 1'b0,
    SECOND_HALF_S = 1'b1
  } rd_state_e;

  rd_state_e         state_q;
  logic [63:0]       mem_q [RESP_FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic [31:0]       readdata_q;
  logic              readdatavalid_q;
  logic              underflow_q;
  logic              push_s;
  logic              pop_s;
  logic [63:0]       head_s;
  logic              unused_bit63_s;

  // Bit 63 is replaced by the valid mark on store, so the input bit is dropped.
  assign unused_bit63_s = response_i[63];

  // Ready is based on the registered full flag, so a pop does not free a slot
  // for a push in the same cycle.
  assign push_s = response_valid_i & ~full_q;
  // The FSM only enters SECOND_HALF_S with a non-empty buffer, so this pop is
  // always legal.
  assign pop_s  = (state_q == SECOND_HALF_S) & read_i;
  // Both halves come from the same head entry; rd_ptr moves only on the pop.
  assign head_s = mem_q[rd_ptr_q];

  // Response storage RAM write port (no reset: contents are qualified by count).
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {1'b1, response_i[62:0]};
    end
  end

  // Next-state computation for pointers, count and status flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CW'(push_s) - CW'(pop_s);
    empty_d = (count_d == {CW{1'b0}});
    full_d  = (count_d == FULL_CNT);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Two-phase read FSM with registered read data, valid and underflow.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= FIRST_HALF_S;
      readdata_q      <= 32'h0000_0000;
      readdatavalid_q <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      case (state_q)
        FIRST_HALF_S: begin
          if (read_i) begin
            readdatavalid_q <= 1'b1;
            if (empty_q) begin
              readdata_q  <= 32'h0000_0000;
              underflow_q <= 1'b1;
            end else begin
              readdata_q <= head_s[31:0];
              state_q    <= SECOND_HALF_S;
            end
          end else begin
            readdatavalid_q <= 1'b0;
          end
        end
        SECOND_HALF_S: begin
          if (read_i) begin
            readdatavalid_q <= 1'b1;
            readdata_q      <= head_s[63:32];
            state_q         <= FIRST_HALF_S;
          end else begin
            readdatavalid_q <= 1'b0;
          end
        end
        default: begin
          state_q         <= FIRST_HALF_S;
          readdatavalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign response_ready_o = ~full_q;
  assign readdata_o       = readdata_q;
  assign readdatavalid_o  = readdatavalid_q;
  assign resp_buf_empty_o = empty_q;
  assign resp_buf_full_o  = full_q;
  assign resp_count_o     = count_q;
  assign underflow_o      = underflow_q;

endmodule

// File: tb/tb_netdma_response_buffer.sv
module tb_netdma_response_buffer;

  logic        clk;
  logic        rst_n;
  logic [63:0] response;
  logic        response_valid;
  logic        response_ready;
  logic        read;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        empty;
  logic        full;
  logic [6:0]  count;
  logic        underflow;

  int total = 0;
  int bad   = 0;

  netdma_response_buffer #(.RESP_FIFO_DEPTH(64)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .response_i       (response),
    .response_valid_i (response_valid),
    .response_ready_o (response_ready),
    .read_i           (read),
    .readdata_o       (readdata),
    .readdatavalid_o  (readdatavalid),
    .resp_buf_empty_o (empty),
    .resp_buf_full_o  (full),
    .resp_count_o     (count),
    .underflow_o      (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] d);
    response_valid = 1'b1;
    response       = d;
    tick();
    response_valid = 1'b0;
  endtask

  // Issues one read and checks the word returned one cycle later.
  task automatic rd(input string tag, input logic [31:0] exp);
    read = 1'b1;
    tick();
    read = 1'b0;
    chk({tag, "_vld"}, 64'(readdatavalid), 64'd1);
    chk(tag, 64'(readdata), 64'(exp));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_full"},  64'(full), 64'd0);
    chk({tag, "_ready"}, 64'(response_ready), 64'd1);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_data"},  64'(readdata), 64'd0);
    chk({tag, "_vld"},   64'(readdatavalid), 64'd0);
    chk({tag, "_uflow"}, 64'(underflow), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    response = 64'd0;
    response_valid = 1'b0;
    read = 1'b0;
    repeat (3) tick();
    chk_reset_state("rst");
    rst_n = 1'b1;
    tick();

    // Single entry, two halves.
    push(64'h0000_00AA_0000_0040);
    chk("t1_empty_after_push", 64'(empty), 64'd0);
    chk("t1_count_after_push", 64'(count), 64'd1);
    read = 1'b1;
    tick();
    chk("t1_lo_vld", 64'(readdatavalid), 64'd1);
    chk("t1_lo", 64'(readdata), 64'h0000_0040);
    tick();
    read = 1'b0;
    chk("t1_hi_vld", 64'(readdatavalid), 64'd1);
    chk("t1_hi", 64'(readdata), 64'h8000_00AA);
    chk("t1_empty", 64'(empty), 64'd1);
    chk("t1_count", 64'(count), 64'd0);
    tick();
    chk("t1_vld_low", 64'(readdatavalid), 64'd0);
    chk("t1_hold", 64'(readdata), 64'h8000_00AA);

    // Read while empty: zero word, sticky underflow, FSM stays on first half.
    rd("t2_empty_rd", 32'h0000_0000);
    chk("t2_uflow", 64'(underflow), 64'd1);
    tick();
    chk("t2_vld_low", 64'(readdatavalid), 64'd0);
    chk("t2_uflow_sticky", 64'(underflow), 64'd1);
    push(64'h0000_0011_0000_0022);
    rd("t2_lo", 32'h0000_0022);
    rd("t2_hi", 32'h8000_0011);
    chk("t2_uflow_still", 64'(underflow), 64'd1);

    // Fill to full, extra valid held off, drain in order.
    for (int i = 0; i < 64; i++) push({32'(i + 256), 32'(i)});
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_ready", 64'(response_ready), 64'd0);
    chk("t3_count", 64'(count), 64'd64);
    response_valid = 1'b1;
    response = 64'h0000_DEAD_0000_DEAD;
    tick();
    tick();
    response_valid = 1'b0;
    chk("t3_count_held", 64'(count), 64'd64);
    for (int i = 0; i < 64; i++) begin
      rd("t3_lo", 32'(i));
      rd("t3_hi", 32'h8000_0000 | 32'(i + 256));
    end
    chk("t3_empty_after_drain", 64'(empty), 64'd1);
    chk("t3_count_after_drain", 64'(count), 64'd0);

    // Second fill (pointers have wrapped); push refused during pop at full.
    for (int i = 0; i < 64; i++) push({32'(i), 32'(i + 64)});
    chk("t4_full", 64'(full), 64'd1);
    rd("t4_lo0", 32'd64);
    read = 1'b1;
    response_valid = 1'b1;
    response = 64'h0000_0777_0000_0077;
    tick();
    read = 1'b0;
    chk("t4_hi0", 64'(readdata), 64'h8000_0000);
    chk("t4_count_63", 64'(count), 64'd63);
    chk("t4_ready_back", 64'(response_ready), 64'd1);
    tick();
    response_valid = 1'b0;
    chk("t4_count_64", 64'(count), 64'd64);
    for (int i = 1; i < 64; i++) begin
      rd("t4_lo", 32'(i + 64));
      rd("t4_hi", 32'h8000_0000 | 32'(i));
    end
    rd("t4_lo_late", 32'h0000_0077);
    rd("t4_hi_late", 32'h8000_0777);
    chk("t4_empty", 64'(empty), 64'd1);

    // Simultaneous push and pop at count 3.
    push(64'h0000_0A01_0000_00A0);
    push(64'h0000_0B01_0000_00B0);
    push(64'h0000_0C01_0000_00C0);
    chk("t5_count3", 64'(count), 64'd3);
    rd("t5_lo_a", 32'h0000_00A0);
    read = 1'b1;
    response_valid = 1'b1;
    response = 64'h0000_0D01_0000_00D0;
    tick();
    read = 1'b0;
    response_valid = 1'b0;
    chk("t5_hi_a", 64'(readdata), 64'h8000_0A01);
    chk("t5_count_same", 64'(count), 64'd3);
    rd("t5_lo_b", 32'h0000_00B0);
    rd("t5_hi_b", 32'h8000_0B01);
    rd("t5_lo_c", 32'h0000_00C0);
    rd("t5_hi_c", 32'h8000_0C01);
    rd("t5_lo_d", 32'h0000_00D0);
    rd("t5_hi_d", 32'h8000_0D01);
    chk("t5_empty", 64'(empty), 64'd1);

    // Asynchronous reset between the two halves.
    push(64'h0000_0E01_0000_00E0);
    push(64'h0000_0E02_0000_00E2);
    rd("t6_lo_e", 32'h0000_00E0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("t6_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    push(64'h0000_0F01_0000_00F0);
    rd("t6_lo_f", 32'h0000_00F0);
    rd("t6_hi_f", 32'h8000_0F01);
    chk("t6_empty", 64'(empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/netdma_response_buffer.md
# netdma_response_buffer

Stores 64-bit transfer responses from the netdma write/read engine and returns them to the HPS as two consecutive 32-bit reads. It is the read-side counterpart of the descriptor path: software pushes descriptors in as 32-bit halves, and pulls completions out as 32-bit halves. It sits between the engine response output and the HPS slave read port, with status reported to the csr block.

## Interface
- RESP_FIFO_DEPTH, 64: number of 64-bit entries; power of two, ≥ 2.
- clk_i  in  1  single clock for the whole block.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- response_i  in  64  response entry: [31:0] bytes transferred, [63:32] status word (bit 31 forced to 1 on store as the "valid" mark).
- response_valid_i  in  1  response_i is valid this cycle.
- response_ready_o  out  1  buffer accepts an entry this cycle.
- read_i  in  1  HPS read strobe, one word per cycle.
- readdata_o  out  32  returned word.
- readdatavalid_o  out  1  readdata_o is valid.
- resp_buf_empty_o  out  1  no stored entries (to csr).
- resp_buf_full_o  out  1  RESP_FIFO_DEPTH entries stored (to csr).
- resp_count_o  out  $clog2(RESP_FIFO_DEPTH)+1  number of stored entries (to csr).
- underflow_o  out  1  sticky flag: a read arrived while empty; cleared only by reset.

## Operation
- Storage: in-block circular RAM with wr_ptr/rd_ptr of $clog2(RESP_FIFO_DEPTH) bits, wrapping naturally. Count register of width $clog2(RESP_FIFO_DEPTH)+1.
- Push: response_ready_o = !resp_buf_full_o (registered full). An entry is written when response_valid_i & response_ready_o. The stored value is {1'b1, response_i[62:32], response_i[31:0]}.
- Read FSM states (each means "waiting for..."):
  - FIRST_HALF_S: on read_i when not empty, return entry[31:0] and go to SECOND_HALF_S. On read_i when empty, return 32'h0, set underflow_o, and stay.
  - SECOND_HALF_S: on read_i, return entry[63:32], pop the entry (rd_ptr+1, count−1), and go to FIRST_HALF_S. The FSM can only reach this state with a non-empty FIFO, so a pop here is always legal.
- Software contract: an empty FIFO reads as 0. This means bit 31 of the second word is the valid mark, and a first word of 0 from an empty FIFO is distinguishable through resp_buf_empty_o / underflow_o.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, a push is refused in the same cycle as a pop (ready is based on registered full); it is accepted on the next cycle.
- The head entry is read from the RAM at rd_ptr. The same entry is returned for both halves, because rd_ptr only moves on the second-half read.

## Timing
- Reset (rst_n_i low, asynchronous): state = FIRST_HALF_S, pointers = 0, count = 0, resp_buf_empty_o = 1, resp_buf_full_o = 0, response_ready_o = 1, readdata_o = 0, readdatavalid_o = 0, underflow_o = 0. A reset between the two halves discards the partially read entry, and all stored entries are lost.
- Read latency: fixed at 1 cycle. readdatavalid_o is high for exactly one cycle, the cycle after each read_i. Back-to-back reads give back-to-back valid words.
- Push to visibility: an entry written in cycle N makes resp_buf_empty_o low and is readable by a read_i in cycle N+1. Data returns in N+2.
- Flags: empty, full and count are registered and update in the cycle after the push or pop that changes them.
- readdata_o holds its last value when readdatavalid_o is low.

## Test plan
- Reset then one push of 64'h0000_00AA_0000_0040, followed by two reads → 32'h0000_0040 then 32'h8000_00AA, each one cycle after its read. After that, empty = 1 and count = 0.
- Read while empty after reset → readdata_o = 0 and readdatavalid_o = 1 one cycle later. underflow_o goes to 1 and stays; the FSM remains in the first half, so a later push followed by a read returns that entry's low word.
- Fill with RESP_FIFO_DEPTH pushes (low word = index) → full = 1, ready = 0, count = 64. An extra valid is held off. Draining with 128 reads returns indices 0..63 in order, and the pointers wrap correctly on a second fill.
- At full, a second-half read in the same cycle as response_valid_i → the push is refused that cycle and accepted the next cycle. Count goes 64→63→64 with no data lost.
- With push and pop in the same cycle at count 3 → count stays 3 and the data order is preserved.
- Assert rst_n_i mid-cycle after a first-half read → all outputs reach their reset values immediately. The next read after a push returns the low word of the new entry.
